// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the parametrised pipeline controller.
// Stage indices follow the classic PC/IF/ID/EX/MEM/WB layout.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN,
    REDIRECT
  } state_t;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam int DEF_PC_W = 32;

endpackage

// File: rtl/pipe_hi_idx.sv
// Highest-set-bit encoder: index of the top set bit plus an any-set flag.
// Index is 0 when nothing is set; qualify it with any.
module pipe_hi_idx #(
  parameter int W  = 6,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// N-stage pause/flush controller with exception/branch redirect handshake.
// Optional stall watchdog built only when PIPE_STALL_WDOG_EN is defined.
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES      = 6,
  parameter int BR_STAGE    = STG_EX,
  parameter int EXCP_STAGE  = STG_MEM,
  parameter int PC_W        = DEF_PC_W,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] pause_req,
  input  logic              excp_req,
  input  logic [PC_W-1:0]   excp_pc,
  output logic              excp_ack,
  input  logic              br_req,
  input  logic [PC_W-1:0]   br_pc,
  output logic              br_ack,
  output logic [STAGES-1:0] pause,
  output logic [STAGES-1:0] flush,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  input  logic              redirect_ready,
  output logic              stall_timeout
);

  localparam int HW = (STAGES > 1) ? $clog2(STAGES) : 1;

  state_t          state, state_nx;
  logic            rv_nx;
  logic [PC_W-1:0] rpc_nx;
  logic [HW-1:0]   h;
  logic            any;
  logic            ex_hold, br_hold;
  logic            ex_ok, br_ok;
  int              hi;

  pipe_hi_idx #(
    .W  (STAGES),
    .IW (HW)
  ) u_hi (
    .vec (pause_req),
    .idx (h),
    .any (any)
  );

  always_comb begin
    ex_hold  = 1'b0;
    br_hold  = 1'b0;
    pause    = '0;
    flush    = '0;
    excp_ack = 1'b0;
    br_ack   = 1'b0;
    hi       = int'(h);
    for (int i = 0; i < STAGES; i++) begin
      if (pause_req[i] && i > EXCP_STAGE) ex_hold = 1'b1;
      if (pause_req[i] && i >= BR_STAGE) br_hold = 1'b1;
      pause[i] = any && (i <= hi);
      flush[i] = any && (i == hi + 1);
    end
    ex_ok = excp_req && !ex_hold;
    br_ok = br_req && (state == RUN) && !ex_ok && !br_hold;
    // Redirect flushes override any stall on the squashed stages.
    for (int i = 0; i < STAGES; i++) begin
      if (ex_ok && i <= EXCP_STAGE) begin
        pause[i] = 1'b0;
        flush[i] = 1'b1;
      end
      if (br_ok && i < BR_STAGE) begin
        pause[i] = 1'b0;
        flush[i] = 1'b1;
      end
    end
    if (state == REDIRECT) begin
      pause[0] = 1'b0;
      flush[0] = 1'b1;
    end
    excp_ack = ex_ok;
    br_ack   = br_ok;
    if (rst) begin
      pause    = '0;
      flush    = '0;
      excp_ack = 1'b0;
      br_ack   = 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    rv_nx    = redirect_valid;
    rpc_nx   = redirect_pc;
    if (excp_ack) begin
      state_nx = REDIRECT;
      rv_nx    = 1'b1;
      rpc_nx   = excp_pc;
    end else if (br_ack) begin
      state_nx = REDIRECT;
      rv_nx    = 1'b1;
      rpc_nx   = br_pc;
    end else if (state == REDIRECT
                 && redirect_valid
                 && redirect_ready) begin
      state_nx = RUN;
      rv_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_nx;
      redirect_valid <= rv_nx;
      redirect_pc    <= rpc_nx;
    end
  end

`ifdef PIPE_STALL_WDOG_EN
  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || !any) begin
      wd_cnt <= '0;
    end else if (wd_cnt != CW'(STALL_LIMIT)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign stall_timeout = !rst && any
                         && (wd_cnt == CW'(STALL_LIMIT - 1));
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: directed vectors with hand-computed
// per-cycle expectations, checked by an independent negedge monitor.
module tb_pipe_ctrl_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  pause_req = '0;
  logic        excp_req = 1'b0;
  logic [31:0] excp_pc = '0;
  logic        excp_ack;
  logic        br_req = 1'b0;
  logic [31:0] br_pc = '0;
  logic        br_ack;
  logic [5:0]  pause;
  logic [5:0]  flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic        stall_timeout;

  typedef struct {
    string       nm;
    logic [5:0]  p;
    logic [5:0]  f;
    logic        ea;
    logic        ba;
    logic        rv;
    logic [31:0] rpc;
    logic        tmo;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic wd;

  pipe_ctrl_gen #(
    .STAGES      (6),
    .BR_STAGE    (3),
    .EXCP_STAGE  (4),
    .PC_W        (32),
    .STALL_LIMIT (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pause_req      (pause_req),
    .excp_req       (excp_req),
    .excp_pc        (excp_pc),
    .excp_ack       (excp_ack),
    .br_req         (br_req),
    .br_pc          (br_pc),
    .br_ack         (br_ack),
    .pause          (pause),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .stall_timeout  (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %h want %h", nm, fld, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "pause", 32'(pause), 32'(e.p));
        chk(e.nm, "flush", 32'(flush), 32'(e.f));
        chk(e.nm, "excp_ack", 32'(excp_ack), 32'(e.ea));
        chk(e.nm, "br_ack", 32'(br_ack), 32'(e.ba));
        chk(e.nm, "rvalid", 32'(redirect_valid), 32'(e.rv));
        chk(e.nm, "rpc", redirect_pc, e.rpc);
        chk(e.nm, "tmo", 32'(stall_timeout), 32'(e.tmo));
      end
    end
  end

  task automatic step(
    input string nm, input logic r, input logic [5:0] pr,
    input logic er, input logic [31:0] ep,
    input logic br, input logic [31:0] bp, input logic rdy,
    input logic [5:0] xp, input logic [5:0] xf,
    input logic xea, input logic xba, input logic xrv,
    input logic [31:0] xrpc, input logic xt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    pause_req = pr;
    excp_req = er;
    excp_pc = ep;
    br_req = br;
    br_pc = bp;
    redirect_ready = rdy;
    e.nm = nm;
    e.p = xp;
    e.f = xf;
    e.ea = xea;
    e.ba = xba;
    e.rv = xrv;
    e.rpc = xrpc;
    e.tmo = xt;
    q.push_back(e);
  endtask

  initial begin
`ifdef PIPE_STALL_WDOG_EN
    wd = 1'b1;
`else
    wd = 1'b0;
`endif
    //    name      rst pr         er ep            br bp            rdy pause      flush      ea ba rv rpc           t
    step("reset",   1, 6'b000100, 1, 32'h1111_0000, 1, 32'h2222_0000, 0, 6'b000000, 6'b000000, 0, 0, 0, 32'h0, 0);
    step("stall2",  0, 6'b000100, 0, 32'h0, 0, 32'h0, 0, 6'b000111, 6'b001000, 0, 0, 0, 32'h0, 0);
    step("idle0",   0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000000, 0, 0, 0, 32'h0, 0);
    step("stall5",  0, 6'b100000, 0, 32'h0, 0, 32'h0, 0, 6'b111111, 6'b000000, 0, 0, 0, 32'h0, 0);
    step("stall0",  0, 6'b000001, 0, 32'h0, 0, 32'h0, 0, 6'b000001, 6'b000010, 0, 0, 0, 32'h0, 0);
    step("excp",    0, 6'b000000, 1, 32'h1C00_0000, 0, 32'h0, 0, 6'b000000, 6'b011111, 1, 0, 0, 32'h0, 0);
    step("rd_w1",   0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000001, 0, 0, 1, 32'h1C00_0000, 0);
    step("rd_brig", 0, 6'b000000, 0, 32'h0, 1, 32'h9999_0000, 0, 6'b000000, 6'b000001, 0, 0, 1, 32'h1C00_0000, 0);
    step("rd_stl",  0, 6'b000011, 0, 32'h0, 0, 32'h0, 0, 6'b000010, 6'b000101, 0, 0, 1, 32'h1C00_0000, 0);
    step("rd_take", 0, 6'b000000, 0, 32'h0, 0, 32'h0, 1, 6'b000000, 6'b000001, 0, 0, 1, 32'h1C00_0000, 0);
    step("run1",    0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000000, 0, 0, 0, 32'h1C00_0000, 0);
    step("ex_br",   0, 6'b000000, 1, 32'h0000_2000, 1, 32'h0000_3000, 0, 6'b000000, 6'b011111, 1, 0, 0, 32'h1C00_0000, 0);
    step("rd2",     0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000001, 0, 0, 1, 32'h0000_2000, 0);
    step("rd_ex",   0, 6'b000000, 1, 32'h0000_4000, 0, 32'h0, 1, 6'b000000, 6'b011111, 1, 0, 1, 32'h0000_2000, 0);
    step("rd_new",  0, 6'b000000, 0, 32'h0, 0, 32'h0, 1, 6'b000000, 6'b000001, 0, 0, 1, 32'h0000_4000, 0);
    step("br_stl",  0, 6'b000100, 0, 32'h0, 1, 32'h0000_5000, 0, 6'b000000, 6'b001111, 0, 1, 0, 32'h0000_4000, 0);
    step("rd3",     0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000001, 0, 0, 1, 32'h0000_5000, 0);
    step("rst_mid", 1, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000000, 0, 0, 1, 32'h0000_5000, 0);
    step("post_rst",0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000000, 0, 0, 0, 32'h0, 0);
    step("ex_defer",0, 6'b100000, 1, 32'h0000_6000, 0, 32'h0, 0, 6'b111111, 6'b000000, 0, 0, 0, 32'h0, 0);
    step("ex_go",   0, 6'b000000, 1, 32'h0000_6000, 0, 32'h0, 0, 6'b000000, 6'b011111, 1, 0, 0, 32'h0, 0);
    step("rd4",     0, 6'b000000, 0, 32'h0, 0, 32'h0, 1, 6'b000000, 6'b000001, 0, 0, 1, 32'h0000_6000, 0);
    step("br_defer",0, 6'b001000, 0, 32'h0, 1, 32'h0000_7000, 0, 6'b001111, 6'b010000, 0, 0, 0, 32'h0000_6000, 0);
    step("br_go",   0, 6'b000000, 0, 32'h0, 1, 32'h0000_7000, 0, 6'b000000, 6'b000111, 0, 1, 0, 32'h0000_6000, 0);
    step("rd5",     0, 6'b000000, 0, 32'h0, 0, 32'h0, 1, 6'b000000, 6'b000001, 0, 0, 1, 32'h0000_7000, 0);
    step("run2",    0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000000, 0, 0, 0, 32'h0000_7000, 0);
    step("ex_stl4", 0, 6'b010000, 1, 32'h0000_8000, 0, 32'h0, 0, 6'b000000, 6'b111111, 1, 0, 0, 32'h0000_7000, 0);
    step("rd6",     0, 6'b000000, 0, 32'h0, 0, 32'h0, 1, 6'b000000, 6'b000001, 0, 0, 1, 32'h0000_8000, 0);
    step("run3",    0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000000, 0, 0, 0, 32'h0000_8000, 0);
    for (int k = 1; k <= 10; k++)
      step($sformatf("wd_a%0d", k), 0, 6'b000010, 0, 32'h0, 0, 32'h0, 0,
           6'b000011, 6'b000100, 0, 0, 0, 32'h0000_8000, wd && (k == 8));
    step("wd_clr",  0, 6'b000000, 0, 32'h0, 0, 32'h0, 0, 6'b000000, 6'b000000, 0, 0, 0, 32'h0000_8000, 0);
    for (int k = 1; k <= 9; k++)
      step($sformatf("wd_b%0d", k), 0, 6'b100000, 0, 32'h0, 0, 32'h0, 0,
           6'b111111, 6'b000000, 0, 0, 0, 32'h0000_8000, wd && (k == 8));
    for (int k = 0; k < 20 && q.size() > 0; k++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
